// File: rtl/uart_tx_sched_pkg.sv
// ============================================================================
// Module      : uart_tx_sched_pkg
// Description : Shared types and default constants for the UART TX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_sched_pkg;

    localparam int unsigned DEF_NUM_REQ      = 2;
    localparam int unsigned DEF_MAX_BYTES    = 2;
    localparam int unsigned DEF_BUSY_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request at or
//               above the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    // Scan upward from the pointer and take the first requester found
    always_comb begin
        logic found;
        int   cand;
        found     = 1'b0;
        cand      = 0;
        winner_o  = '0;
        any_req_o = |req_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                winner_o = IDX_W'(cand);
            end
        end
        gnt_o = any_req_o ? (NUM_REQ'(1) << winner_o) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin scheduler sharing one UART_TX between several
//               requesters; sends each latched frame LSB byte first, pacing
//               bytes on the transmitter's BUSY signal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int MAX_BYTES    = DEF_MAX_BYTES,
    parameter int DATA_WIDTH   = 8 * MAX_BYTES,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1),
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          err_o,
    input  logic                          tx_busy_i,
    output logic [7:0]                    p_data_o,
    output logic                          data_valid_o,
    output logic                          active_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d, winner_q, winner_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [LEN_W-1:0]        len_q, len_d, idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_flag_q, err_flag_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d, done_q, done_d;
    logic                    err_q, err_d, dv_q, dv_d, active_q, active_d;
    logic [7:0]              p_data_q, p_data_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_winner;
    logic                    arb_any;
    logic [LEN_W-1:0]        win_len_raw, win_len;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    timeout_hit, more_bytes;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .winner_o  (arb_winner),
        .any_req_o (arb_any)
    );

    assign win_len_raw = req_len_i[arb_winner*LEN_W +: LEN_W];
    assign win_data    = req_data_i[arb_winner*DATA_WIDTH +: DATA_WIDTH];
    // Over-long requests are clamped so the byte loop never runs past the frame
    assign win_len     = (win_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : win_len_raw;
    // The transmitter gets exactly BUSY_TIMEOUT idle cycles in WAIT_HI before abort
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(BUSY_TIMEOUT));
    assign more_bytes  = (({1'b0, idx_q} + (LEN_W+1)'(1)) < {1'b0, len_q});

    // State register; reset mid-frame abandons the frame without a DONE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = (win_len == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!tx_busy_i) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (timeout_hit) begin
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy_i) begin
                    state_d = more_bytes ? ST_ISSUE : ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every output leaves through a flop
    always_comb begin
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        data_d     = data_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        dv_d       = 1'b0;
        p_data_d   = p_data_q;
        active_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    winner_d = arb_winner;
                    data_d   = win_data;
                    len_d    = win_len;
                    idx_d    = '0;
                    gnt_d    = arb_gnt;
                end
            end
            ST_ISSUE: begin
                if (!tx_busy_i) begin
                    dv_d     = 1'b1;
                    p_data_d = data_q[{idx_q, 3'b000} +: 8];
                    cnt_d    = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!tx_busy_i) begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        err_flag_d = 1'b1;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy_i && more_bytes) begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            ST_FINISH: begin
                done_d     = NUM_REQ'(1) << winner_q;
                err_d      = err_flag_q;
                ptr_d      = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
                idx_d      = '0;
                err_flag_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            winner_q   <= '0;
            data_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            dv_q       <= 1'b0;
            p_data_q   <= 8'h00;
            active_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            data_q     <= data_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dv_q       <= dv_d;
            p_data_q   <= p_data_d;
            active_q   <= active_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign data_valid_o = dv_q;
    assign p_data_o     = p_data_q;
    assign active_o     = active_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Scoreboard bench for uart_tx_scheduler with a simple UART
//               BUSY model and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;
    import uart_tx_sched_pkg::*;

    localparam int N  = DEF_NUM_REQ;
    localparam int MB = DEF_MAX_BYTES;
    localparam int DW = 8 * MB;
    localparam int LW = $clog2(MB + 1);
    localparam int TO = DEF_BUSY_TIMEOUT;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt_o, done_o;
    logic            err_o, tx_busy, data_valid_o, active_o;
    logic [7:0]      p_data_o;

    uart_tx_scheduler #(.NUM_REQ(N), .MAX_BYTES(MB), .BUSY_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_data_i(req_data),
        .req_len_i(req_len), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
        .tx_busy_i(tx_busy), .p_data_o(p_data_o), .data_valid_o(data_valid_o),
        .active_o(active_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- UART_TX BUSY model plus optional foreign traffic ----------------
    logic mdl_busy;
    int   bcnt;
    bit   uart_en = 1'b1, rnd_busy = 1'b0;
    int   fb_until = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy <= 1'b0;
            bcnt     <= 0;
        end else if (uart_en && data_valid_o) begin
            mdl_busy <= 1'b1;
            bcnt     <= rnd_busy ? int'($urandom_range(1, 12)) : 11;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            mdl_busy <= 1'b0;
            bcnt     <= 0;
        end
    end
    assign tx_busy = mdl_busy | (cyc < fb_until);

    // ---------------- Reference model: frame-level expectations ----------------
    typedef struct {
        int             win;
        int             nb;
        logic [DW-1:0]  data;
        bit             err;
    } frame_t;

    frame_t        exp_q[$];
    logic [DW-1:0] dat[N];
    int            len_a[N];
    int            mptr = 0;
    bit            to_mode = 1'b0;

    function automatic int pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(mptr + k) % N]) return (mptr + k) % N;
        end
        return 0;
    endfunction

    task automatic push_frame(input int p);
        frame_t f;
        f.win  = p;
        f.data = dat[p];
        if (to_mode) begin
            f.nb  = (len_a[p] == 0) ? 0 : 1;
            f.err = (len_a[p] != 0);
        end else begin
            f.nb  = (len_a[p] > MB) ? MB : len_a[p];
            f.err = 1'b0;
        end
        exp_q.push_back(f);
        mptr = (p + 1) % N;
    endtask

    // ---------------- Monitor ----------------
    bit     in_frame = 1'b0, mon_hold = 1'b0, gbusy = 1'b0, prev_busy = 1'b0;
    frame_t cur;
    int     bi = 0, gcyc = 0, dvcyc = 0, fallcyc = 0;

    always @(negedge clk) begin
        if (!rst_n || mon_hold) begin
            in_frame  = 1'b0;
            prev_busy = tx_busy;
        end else begin
            if (prev_busy && !tx_busy) fallcyc = cyc;
            prev_busy = tx_busy;
            if (data_valid_o && tx_busy) chk("dv_while_busy", 1, 0);
            if (|gnt_o) begin
                chk("gnt_in_frame", in_frame, 0);
                chk("gnt_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("gnt_winner", gnt_o, N'(1) << cur.win);
                    in_frame = 1'b1;
                    bi       = 0;
                    gcyc     = cyc;
                    gbusy    = tx_busy;
                end
            end
            if (data_valid_o) begin
                chk("dv_in_frame", in_frame, 1);
                if (in_frame) begin
                    logic [DW-1:0] sh;
                    sh = cur.data >> (8 * bi);
                    chk("dv_count", bi < cur.nb, 1);
                    chk("p_data", p_data_o, sh[7:0]);
                    if (bi == 0 && !gbusy) chk("dv_latency", cyc, gcyc + 1);
                    bi++;
                    dvcyc = cyc;
                end
            end
            if (|done_o) begin
                chk("done_in_frame", in_frame, 1);
                if (in_frame) begin
                    chk("done_onehot", done_o, N'(1) << cur.win);
                    chk("err", err_o, cur.err);
                    chk("byte_count", bi, cur.nb);
                    if (cur.nb == 0)  chk("done_lat_len0", cyc, gcyc + 1);
                    else if (cur.err) chk("done_lat_timeout", cyc, dvcyc + TO + 1);
                    else              chk("done_lat", cyc, fallcyc + 2);
                    in_frame = 1'b0;
                end
            end else if (err_o) begin
                chk("err_without_done", 1, 0);
            end
            chk("active", active_o, in_frame);
        end
    end

    // ---------------- Stimulus ----------------
    task automatic drive(input int i);
        req_data[i*DW +: DW] = dat[i];
        req_len[i*LW +: LW]  = LW'(len_a[i]);
    endtask

    task automatic scramble(input int i);
        req_data[i*DW +: DW] = DW'($urandom);
        req_len[i*LW +: LW]  = LW'($urandom);
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((req != 0 || exp_q.size() != 0 || in_frame) && guard < 3000) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_o[i]) begin
                    req[i] = 1'b0;
                    scramble(i);
                end
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            chk("round_timeout", 1, 0);
            exp_q.delete();
            req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    // Raise every requester in mask together; each drops its REQ after its GNT
    task automatic run_round(input logic [N-1:0] mask, input bit rnd, input int fb);
        logic [N-1:0] pend;
        int p;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (rnd) begin
                    dat[i]   = DW'($urandom);
                    len_a[i] = int'($urandom_range(0, MB + 1));
                end
                drive(i);
            end
        end
        pend = mask;
        while (pend != 0) begin
            p = pick(pend);
            push_frame(p);
            pend[p] = 1'b0;
        end
        fb_until = cyc + fb;
        req = mask;
        @(negedge clk);
        chk("gnt_latency", |gnt_o, 1);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_dv", data_valid_o, 0);
        chk("rst_pdata", p_data_o, 8'h00);
        chk("rst_active", active_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 2-byte frame
        dat[0] = 16'hA55A; len_a[0] = 2;
        run_round(2'b01, 1'b0, 0);

        // Zero-length frame on requester 1
        dat[1] = 16'hBEEF; len_a[1] = 0;
        run_round(2'b10, 1'b0, 0);

        // Held contention, one byte each: order 0,1,0,1
        begin
            int dn = 0, guard = 0;
            dat[0] = 16'h0011; len_a[0] = 1; drive(0);
            dat[1] = 16'h0022; len_a[1] = 1; drive(1);
            for (int k = 0; k < 4; k++) push_frame(pick(2'b11));
            req = 2'b11;
            while (dn < 4 && guard < 1000) begin
                @(negedge clk);
                if (|done_o) dn++;
                guard++;
            end
            req = '0;
            if (guard >= 1000) begin
                chk("contention_timeout", 1, 0);
                exp_q.delete();
            end
            wait_done();
        end

        // Length above MAX_BYTES is clamped
        dat[0] = 16'h1234; len_a[0] = 3;
        run_round(2'b01, 1'b0, 0);

        // Busy timeout: transmitter never responds
        uart_en = 1'b0; to_mode = 1'b1;
        dat[0] = 16'h77C3; len_a[0] = 2;
        run_round(2'b01, 1'b0, 0);
        uart_en = 1'b1; to_mode = 1'b0;
        dat[0] = 16'h4455; len_a[0] = 1;
        dat[1] = 16'h6677; len_a[1] = 2;
        run_round(2'b11, 1'b0, 0);

        // Randomized rounds with variable BUSY length and foreign traffic
        rnd_busy = 1'b1;
        for (int r = 0; r < 30; r++) begin
            run_round(N'($urandom_range(1, (1 << N) - 1)), 1'b1,
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 20)) : 0);
        end
        rnd_busy = 1'b0;

        // Reset in the middle of a frame
        begin
            int guard = 0;
            mon_hold = 1'b1;
            exp_q.delete();
            dat[0] = 16'hA55A; len_a[0] = 2; drive(0);
            req = 2'b01;
            while (!data_valid_o && guard < 200) begin
                @(negedge clk);
                if (gnt_o[0]) req[0] = 1'b0;
                guard++;
            end
            chk("rst_test_dv_seen", data_valid_o, 1);
            req = '0;
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_dv", data_valid_o, 0);
            chk("midrst_active", active_o, 0);
            chk("midrst_pdata", p_data_o, 8'h00);
            chk("midrst_done", done_o, 0);
            chk("midrst_gnt", gnt_o, 0);
            mptr = 0;
            repeat (3) begin
                @(negedge clk);
                chk("rst_hold_done", done_o, 0);
            end
            rst_n = 1'b1;
            @(negedge clk);
            mon_hold = 1'b0;
            dat[1] = 16'h3CC3; len_a[1] = 2;
            run_round(2'b10, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
